// File: rtl/pc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_pkg : next-PC select codes and width helpers for pc_sequencer     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pc_pkg;

  localparam logic [1:0] NPC_SEQ = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_JMP = 2'd2;
  localparam logic [1:0] NPC_RET = 2'd3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Number of low address bits that must be zero for an instruction-aligned target.
  function automatic int align_bits(input int instr_bytes);
    return clog2(instr_bytes);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ras_stack : circular return-address LIFO; full push drops the oldest |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ras_stack
  import pc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top_data,
  output logic         empty,
  output logic         full,
  output logic         overflow
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic             pop_ok;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign pop_ok   = pop && !empty;
  assign overflow = push && !pop_ok && full;
  assign top_data = mem_q[top_q];

  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = top_q;
    if (push && pop_ok) begin
      // Simultaneous pop+push replaces the top entry in place.
      wr_en = 1'b1;
    end else if (push) begin
      top_d  = top_q + PTR_W'(1);
      wr_idx = top_q + PTR_W'(1);
      wr_en  = 1'b1;
      if (!full) count_d = count_q + CNT_W'(1);
    end else if (pop_ok) begin
      top_d   = top_q - PTR_W'(1);
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      top_q   <= '0;
      count_q <= '0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem_q[wr_idx] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_sequencer : fetch PC register with branch/jump/call/ret and RAS   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter int                INSTR_BYTES = 4,
  parameter int                RAS_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              outputEnable,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic              call,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              ret,
  output logic [ADDR_W-1:0] currentPointer,
  output logic [ADDR_W-1:0] pc_next_seq,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_overflow,
  output logic              ras_underflow,
  output logic              misalign
);

  localparam int                ALIGN_BITS = align_bits(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] LOW_MASK   = ADDR_W'((64'(1) << ALIGN_BITS) - 64'(1));

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              misalign_q, misalign_d;

  logic              adv;
  logic [1:0]        npc_sel;
  logic [ADDR_W-1:0] raw_target;
  logic              ras_push, ras_pop;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_ovf;

  assign pc_next_seq    = pc_q + ADDR_W'(INSTR_BYTES);
  assign currentPointer = pc_q;
  assign ras_overflow   = overflow_q;
  assign ras_underflow  = underflow_q;
  assign misalign       = misalign_q;

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_next_seq),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_ovf)
  );

  always_comb begin
    adv      = outputEnable && !stall;
    npc_sel  = NPC_SEQ;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    // ret on an empty stack falls back to sequential fetch.
    if (ret) begin
      npc_sel  = ras_empty ? NPC_SEQ : NPC_RET;
      ras_pop  = adv && !ras_empty;
      ras_push = adv && call;
    end else if (call) begin
      npc_sel  = NPC_JMP;
      ras_push = adv;
    end else if (jump) begin
      npc_sel = NPC_JMP;
    end else if (branch_taken) begin
      npc_sel = NPC_BR;
    end

    case (npc_sel)
      NPC_SEQ: raw_target = pc_next_seq;
      NPC_BR:  raw_target = branch_target;
      NPC_JMP: raw_target = jump_target;
      default: raw_target = ras_top;
    endcase

    pc_d        = pc_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    misalign_d  = 1'b0;
    if (adv) begin
      pc_d        = raw_target & ~LOW_MASK;
      overflow_d  = ras_ovf;
      underflow_d = ret && ras_empty;
      misalign_d  = (npc_sel != NPC_SEQ) && ((raw_target & LOW_MASK) != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_VEC;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      misalign_q  <= misalign_d;
    end
  end

endmodule
`default_nettype wire
